// File: rtl/conv_psum_acmlt.sv
// Partial-sum accumulator for convolution MAC results (INT8/INT16/FP16-style exponent alignment).
// Define CONV_PSUM_ACMLT_SAT_EN to saturate on overflow; otherwise the sum wraps modulo 2^PSUM_W.
`timescale 1ns/1ps

module conv_psum_acmlt #(
    parameter int unsigned PSUM_W    = 48,
    parameter int unsigned SIM_DELAY = 1
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              aclken,
    input  logic [1:0]        calfmt,
    input  logic [11:0]       acmlt_len,
    input  logic [7:0]        mac_out_exp,
    input  logic [39:0]       mac_out_frac,
    input  logic              mac_out_valid,
    output logic [7:0]        psum_exp,
    output logic [PSUM_W-1:0] psum_frac,
    output logic              psum_valid,
    output logic              psum_ovf,
    output logic              acmlt_busy
);

    localparam int unsigned FRAC_W = 40;
    localparam int unsigned LEN_W  = 12;
    localparam int unsigned EXP_W  = 8;
    localparam int unsigned SHW    = $clog2(PSUM_W);
    localparam logic [1:0]       FMT_FP16 = 2'b10;
    localparam logic [EXP_W-1:0] SH_MAX   = EXP_W'(PSUM_W - 1);
`ifdef CONV_PSUM_ACMLT_SAT_EN
    localparam logic signed [PSUM_W-1:0] ACC_MAX = {1'b0, {(PSUM_W-1){1'b1}}};
    localparam logic signed [PSUM_W-1:0] ACC_MIN = {1'b1, {(PSUM_W-1){1'b0}}};
`endif

    // SIM_DELAY is carried for interface compatibility only; the model is zero-delay.
    if (PSUM_W < 44 || PSUM_W > 64 || SIM_DELAY > 1000) begin : g_bad_param
        $error("conv_psum_acmlt: parameter out of range");
    end

    logic [LEN_W-1:0]         r_cnt;
    logic [LEN_W-1:0]         r_len;
    logic [1:0]               r_fmt;
    logic signed [PSUM_W-1:0] r_acc;
    logic [EXP_W-1:0]         r_acc_exp;
    logic                     r_ovf;
    logic [EXP_W-1:0]         r_psum_exp;
    logic [PSUM_W-1:0]        r_psum_frac;
    logic                     r_psum_valid;
    logic                     r_psum_ovf;
    logic                     r_busy;

    logic                     w_beat;
    logic                     w_first;
    logic                     w_last;
    logic                     w_is_fp;
    logic [LEN_W-1:0]         w_len;
    logic [1:0]               w_fmt;
    logic [LEN_W-1:0]         w_cnt_nxt;
    logic signed [PSUM_W-1:0] w_frac;
    logic                     w_in_gt;
    logic [EXP_W-1:0]         w_diff;
    logic [SHW-1:0]           w_sh;
    logic                     w_add;
    logic signed [PSUM_W-1:0] w_op_a;
    logic signed [PSUM_W-1:0] w_op_b;
    logic signed [PSUM_W-1:0] w_sum;
    logic                     w_ovf_beat;
    logic signed [PSUM_W-1:0] w_acc_nxt;
    logic [EXP_W-1:0]         w_exp_nxt;
    logic                     w_ovf_nxt;

    // Group bookkeeping: format and length come live on the first beat, latched copies after.
    always_comb begin
        w_beat    = aclken & mac_out_valid;
        w_first   = (r_cnt == '0);
        w_len     = w_first ? acmlt_len : r_len;
        w_fmt     = w_first ? calfmt : r_fmt;
        w_is_fp   = (w_fmt == FMT_FP16);
        w_last    = (r_cnt == w_len);
        w_cnt_nxt = w_last ? '0 : r_cnt + LEN_W'(1);
        w_frac    = {{(PSUM_W-FRAC_W){mac_out_frac[FRAC_W-1]}}, mac_out_frac};
        w_in_gt   = (mac_out_exp > r_acc_exp);
        w_diff    = w_in_gt ? (mac_out_exp - r_acc_exp) : (r_acc_exp - mac_out_exp);
        w_sh      = SHW'((w_diff > SH_MAX) ? SH_MAX : w_diff);
    end

    // Beat arithmetic: align the smaller-exponent operand, add, detect signed overflow.
    always_comb begin
        w_add     = 1'b0;
        w_op_a    = r_acc;
        w_op_b    = w_frac;
        w_acc_nxt = r_acc;
        w_exp_nxt = r_acc_exp;
        if (w_first) begin
            w_acc_nxt = w_frac;
            w_exp_nxt = w_is_fp ? mac_out_exp : '0;
        end else if (!w_is_fp) begin
            w_add = 1'b1;
        end else if (w_frac == '0) begin
            w_add = 1'b0;
        end else if (r_acc == '0) begin
            w_acc_nxt = w_frac;
            w_exp_nxt = mac_out_exp;
        end else if (w_in_gt) begin
            w_add     = 1'b1;
            w_op_a    = r_acc >>> w_sh;
            w_exp_nxt = mac_out_exp;
        end else begin
            w_add  = 1'b1;
            w_op_b = w_frac >>> w_sh;
        end

        w_sum      = w_op_a + w_op_b;
        w_ovf_beat = w_add & (w_op_a[PSUM_W-1] == w_op_b[PSUM_W-1])
                           & (w_sum[PSUM_W-1] != w_op_a[PSUM_W-1]);
        if (w_add) begin
            w_acc_nxt = w_sum;
`ifdef CONV_PSUM_ACMLT_SAT_EN
            if (w_ovf_beat) begin
                w_acc_nxt = w_op_a[PSUM_W-1] ? ACC_MIN : ACC_MAX;
            end
`endif
        end
        w_ovf_nxt = w_first ? 1'b0 : (r_ovf | w_ovf_beat);
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_cnt        <= '0;
            r_len        <= '0;
            r_fmt        <= '0;
            r_acc        <= '0;
            r_acc_exp    <= '0;
            r_ovf        <= 1'b0;
            r_psum_exp   <= '0;
            r_psum_frac  <= '0;
            r_psum_valid <= 1'b0;
            r_psum_ovf   <= 1'b0;
            r_busy       <= 1'b0;
        end else if (w_beat) begin
            if (w_first) begin
                r_len <= acmlt_len;
                r_fmt <= calfmt;
            end
            r_cnt        <= w_cnt_nxt;
            r_acc        <= w_acc_nxt;
            r_acc_exp    <= w_exp_nxt;
            r_ovf        <= w_ovf_nxt;
            r_busy       <= (w_cnt_nxt != '0);
            r_psum_valid <= w_last;
            if (w_last) begin
                r_psum_frac <= w_acc_nxt;
                r_psum_exp  <= w_is_fp ? w_exp_nxt : '0;
                r_psum_ovf  <= w_ovf_nxt;
            end
        end else if (aclken) begin
            r_psum_valid <= 1'b0;
        end
    end

    assign psum_exp   = r_psum_exp;
    assign psum_frac  = r_psum_frac;
    assign psum_valid = r_psum_valid;
    assign psum_ovf   = r_psum_ovf;
    assign acmlt_busy = r_busy;

endmodule

// File: tb/tb_conv_psum_acmlt.sv
// Self-checking bench for conv_psum_acmlt: directed literal cases plus a randomized run
// checked every cycle against a group-level behavioural model.
`timescale 1ns/1ps

module tb_conv_psum_acmlt;

    localparam int PW = 48;
    localparam longint ACC_MAXV = (longint'(1) <<< (PW-1)) - 1;
    localparam longint ACC_MINV = -(longint'(1) <<< (PW-1));
    localparam logic [39:0] BIG_POS = 40'h7F_FFFF_FFFF;

    logic          aclk = 1'b0;
    logic          areset;
    logic          aclken;
    logic [1:0]    calfmt;
    logic [11:0]   acmlt_len;
    logic [7:0]    mac_out_exp;
    logic [39:0]   mac_out_frac;
    logic          mac_out_valid;
    logic [7:0]    psum_exp;
    logic [PW-1:0] psum_frac;
    logic          psum_valid;
    logic          psum_ovf;
    logic          acmlt_busy;

    conv_psum_acmlt #(.PSUM_W(PW), .SIM_DELAY(1)) u_dut (
        .aclk          (aclk),
        .areset        (areset),
        .aclken        (aclken),
        .calfmt        (calfmt),
        .acmlt_len     (acmlt_len),
        .mac_out_exp   (mac_out_exp),
        .mac_out_frac  (mac_out_frac),
        .mac_out_valid (mac_out_valid),
        .psum_exp      (psum_exp),
        .psum_frac     (psum_frac),
        .psum_valid    (psum_valid),
        .psum_ovf      (psum_ovf),
        .acmlt_busy    (acmlt_busy)
    );

    always #5 aclk = ~aclk;

    typedef struct { logic [7:0] e; logic [39:0] f; } beat_t;
    typedef struct { longint frac; int exp; bit ovf; int cyc; } got_t;

    int     n_total = 0;
    int     n_bad   = 0;
    bit     chk_on  = 0;
    bit     en_q    = 0;
    int     cyc     = 0;

    beat_t  m_q[$];
    int     m_len   = 0;
    logic [1:0] m_fmt = 2'b00;
    bit     m_valid = 0;
    bit     m_busy  = 0;
    bit     m_ovf   = 0;
    longint m_frac  = 0;
    int     m_exp   = 0;
    got_t   got_q[$];

    task automatic chk(input string name, input logic signed [63:0] got, input logic signed [63:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got=%0d want=%0d (t=%0t)", name, got, want, $time);
        end
    endtask

    function automatic longint add_chk(input longint a, input longint b, inout bit ovf);
        longint s = a + b;
        if (s > ACC_MAXV || s < ACC_MINV) begin
            ovf = 1'b1;
`ifdef CONV_PSUM_ACMLT_SAT_EN
            s = (s > ACC_MAXV) ? ACC_MAXV : ACC_MINV;
`else
            s = (s <<< (64-PW)) >>> (64-PW);
`endif
        end
        return s;
    endfunction

    // Reduce a whole collected group to its expected partial sum.
    function automatic void fold_group(input logic [1:0] fmt, output longint r, output int re, output bit rovf);
        bit     fp  = (fmt == 2'b10);
        longint acc = 0;
        int     e   = 0;
        rovf = 1'b0;
        foreach (m_q[i]) begin
            longint f  = longint'(signed'(m_q[i].f));
            int     ie = int'(m_q[i].e);
            int     d  = (ie > e) ? ie - e : e - ie;
            if (d > PW-1) d = PW-1;
            if (i == 0) begin
                acc = f;
                e   = fp ? ie : 0;
            end else if (!fp) begin
                acc = add_chk(acc, f, rovf);
            end else if (f != 0) begin
                if (acc == 0) begin
                    acc = f;
                    e   = ie;
                end else if (ie > e) begin
                    acc = add_chk(acc >>> d, f, rovf);
                    e   = ie;
                end else begin
                    acc = add_chk(acc, f >>> d, rovf);
                end
            end
        end
        r  = acc;
        re = e;
    endfunction

    // Behavioural model: collect beats per group, fold on the last one.
    always @(posedge aclk) begin
        en_q = aclken;
        cyc++;
        if (areset) begin
            m_q.delete();
            m_valid = 0; m_busy = 0; m_frac = 0; m_exp = 0; m_ovf = 0;
        end else if (aclken) begin
            m_valid = 0;
            if (mac_out_valid) begin
                if (m_q.size() == 0) begin
                    m_len = int'(acmlt_len);
                    m_fmt = calfmt;
                end
                m_q.push_back('{e: mac_out_exp, f: mac_out_frac});
                if (m_q.size() == m_len + 1) begin
                    fold_group(m_fmt, m_frac, m_exp, m_ovf);
                    m_valid = 1;
                    m_q.delete();
                end
                m_busy = (m_q.size() != 0);
            end
        end
    end

    // Every-cycle comparison against the model, plus capture of each new result pulse.
    always @(negedge aclk) begin
        if (chk_on) begin
            chk("psum_valid", psum_valid, m_valid);
            chk("acmlt_busy", acmlt_busy, m_busy);
            chk("psum_frac", signed'(psum_frac), m_frac);
            chk("psum_exp", psum_exp, m_exp);
            chk("psum_ovf", psum_ovf, m_ovf);
            if (psum_valid === 1'b1 && en_q)
                got_q.push_back('{frac: longint'(signed'(psum_frac)), exp: int'(psum_exp), ovf: psum_ovf, cyc: cyc});
        end
    end

    task automatic beat(input logic [7:0] e, input logic [39:0] f);
        mac_out_valid = 1'b1;
        mac_out_exp   = e;
        mac_out_frac  = f;
        @(negedge aclk);
        mac_out_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge aclk);
    endtask

    task automatic expect_psum(input string name, input longint frac, input int exp, input bit ovf, output int stamp);
        got_t g;
        stamp = -1;
        for (int k = 0; k < 40 && got_q.size() == 0; k++) @(negedge aclk);
        if (got_q.size() == 0) begin
            chk({name, "_timeout"}, 0, 1);
        end else begin
            g = got_q.pop_front();
            stamp = g.cyc;
            chk({name, "_frac"}, g.frac, frac);
            chk({name, "_exp"}, g.exp, exp);
            chk({name, "_ovf"}, g.ovf, ovf);
        end
    endtask

    initial begin
        int st;
        int st0;
        int vals[4];
        areset = 1'b1; aclken = 1'b1; calfmt = 2'b00; acmlt_len = '0;
        mac_out_exp = '0; mac_out_frac = '0; mac_out_valid = 1'b0;
        idle(3);
        chk("rst_valid", psum_valid, 0);
        chk("rst_frac", signed'(psum_frac), 0);
        chk("rst_busy", acmlt_busy, 0);
        chk("rst_ovf", psum_ovf, 0);
        chk_on = 1;
        areset = 1'b0;
        idle(2);

        // INT16 with gaps between beats
        calfmt = 2'b01; acmlt_len = 12'd3;
        vals = '{10, -4, 7, 100};
        for (int i = 0; i < 4; i++) begin
            if (i > 0) idle($urandom_range(0, 6));
            beat(8'd0, 40'(vals[i]));
            if (i == 0) chk("busy_mid", acmlt_busy, 1);
        end
        expect_psum("int16_sum", 113, 0, 0, st);

        // FP16 alignment, incoming exponent larger
        calfmt = 2'b10; acmlt_len = 12'd1;
        beat(8'd20, 40'd1024);
        beat(8'd22, 40'd512);
        expect_psum("fp_align", 768, 22, 0, st);

        // FP16 zero handling
        acmlt_len = 12'd2;
        beat(8'd15, 40'd0);
        beat(8'd30, 40'd256);
        beat(8'd30, 40'd0);
        expect_psum("fp_zero", 256, 30, 0, st);

        // Length 0: back-to-back single-beat groups
        calfmt = 2'b00; acmlt_len = 12'd0;
        for (int i = 1; i <= 4; i++) beat(8'd0, 40'(i));
        for (int i = 1; i <= 4; i++) begin
            expect_psum("len0", longint'(i), 0, 0, st);
            if (i == 1) st0 = st;
            else chk("len0_b2b", st - st0, i - 1);
        end

        // Mid-group format/length changes are ignored
        calfmt = 2'b01; acmlt_len = 12'd2;
        beat(8'd3, 40'd5);
        calfmt = 2'b10; acmlt_len = 12'd0;
        beat(8'd9, 40'd6);
        beat(8'd1, 40'd7);
        expect_psum("latch_cfg", 18, 0, 0, st);

        // Clock enable low freezes state and holds the result pulse
        calfmt = 2'b00; acmlt_len = 12'd1;
        beat(8'd0, 40'd3);
        aclken = 1'b0; mac_out_valid = 1'b1; mac_out_frac = 40'd100;
        idle(2);
        aclken = 1'b1; mac_out_valid = 1'b0;
        beat(8'd0, 40'd4);
        aclken = 1'b0;
        idle(3);
        aclken = 1'b1;
        expect_psum("clken", 7, 0, 0, st);
        chk("clken_single", got_q.size(), 0);

        // Large INT16 accumulation into overflow
        calfmt = 2'b01; acmlt_len = 12'd511;
        repeat (512) beat(8'd0, BIG_POS);
`ifdef CONV_PSUM_ACMLT_SAT_EN
        expect_psum("ovf_sum", ACC_MAXV, 0, 1, st);
`else
        expect_psum("ovf_sum", -512, 0, 1, st);
`endif

        // Reset mid-group discards the partial sum
        got_q.delete();
        calfmt = 2'b00; acmlt_len = 12'd3;
        beat(8'd0, 40'd9);
        beat(8'd0, 40'd9);
        areset = 1'b1;
        idle(1);
        areset = 1'b0;
        chk("rst_mid_busy", acmlt_busy, 0);
        chk("rst_mid_valid", psum_valid, 0);
        repeat (4) beat(8'd0, 40'd5);
        expect_psum("rst_mid", 20, 0, 0, st);
        chk("rst_mid_count", got_q.size(), 0);

        // Randomized traffic checked cycle by cycle against the model
        for (int n = 0; n < 4000; n++) begin
            aclken        = ($urandom_range(0, 7) != 0);
            areset        = ($urandom_range(0, 499) == 0);
            mac_out_valid = ($urandom_range(0, 9) < 6);
            calfmt        = 2'($urandom_range(0, 3));
            acmlt_len     = 12'($urandom_range(0, 4));
            mac_out_exp   = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 60));
            case ($urandom_range(0, 3))
                0:       mac_out_frac = '0;
                1:       mac_out_frac = 40'(int'($urandom_range(0, 2000)) - 1000);
                default: mac_out_frac = {8'($urandom), 32'($urandom)};
            endcase
            @(negedge aclk);
        end
        areset = 1'b0; aclken = 1'b1; mac_out_valid = 1'b0;
        idle(5);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
